// File: rtl/alu_issue_pkg.sv
// Shared opcodes, funct3 shift selectors and FSM state encoding for the ALU issue controller.
package alu_issue_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRx = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WAIT,
        WB
    } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of an OP/OP-IMM instruction into ALU funct fields, operands and rd.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        legal,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic [31:0] operand_0,
    output logic [31:0] operand_1,
    output logic [4:0]  rd
);

    always_comb begin
        legal     = 1'b0;
        funct7    = 7'b0;
        funct3    = instr[14:12];
        operand_0 = rs1_data;
        operand_1 = 32'b0;
        rd        = instr[11:7];
        case (instr[6:0])
            OPCODE_OP: begin
                legal     = 1'b1;
                funct7    = instr[31:25];
                operand_1 = rs2_data;
            end
            OPCODE_OP_IMM: begin
                legal     = 1'b1;
                operand_1 = {{20{instr[31]}}, instr[31:20]};
                // Only shift immediates carry a meaningful funct7 (SRAI vs SRLI).
                if (instr[14:12] == FUNCT3_SLL || instr[14:12] == FUNCT3_SRx) begin
                    funct7 = instr[31:25];
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback controller: accepts one OP/OP-IMM instruction, reads operands, strobes the
// ALU, waits out its latency and emits a single-cycle register writeback.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    output logic        illegal,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        alu_enable,
    output logic [6:0]  alu_funct7,
    output logic [2:0]  alu_funct3,
    output logic [31:0] alu_operand_0,
    output logic [31:0] alu_operand_1,
    input  logic [31:0] alu_destination,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY);

    state_t state;
    state_t state_next;

    logic [31:0]      instr_q;
    logic [31:0]      instr_sel;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             wait_done;

    logic        dec_legal;
    logic [6:0]  dec_funct7;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_operand_0;
    logic [31:0] dec_operand_1;
    logic [4:0]  dec_rd;

    // In IDLE the decoder looks at the offered word so legality is known at the handshake.
    assign instr_sel = (state == IDLE) ? instruction : instr_q;

    alu_issue_decode u_decode (
        .instr     (instr_sel),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .legal     (dec_legal),
        .funct7    (dec_funct7),
        .funct3    (dec_funct3),
        .operand_0 (dec_operand_0),
        .operand_1 (dec_operand_1),
        .rd        (dec_rd)
    );

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = instr_valid && instr_ready;
    assign alu_enable  = (state == ISSUE);
    assign wb_valid    = (state == WB) && (wb_rd != 5'd0);
    assign wait_done   = (state == WAIT) && (wait_cnt == CNT_ONE);
    assign rs1_addr    = (state == IDLE) ? 5'd0 : instr_q[19:15];
    assign rs2_addr    = (state == IDLE) ? 5'd0 : instr_q[24:20];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && dec_legal) begin
                    state_next = READ;
                end
            end
            READ:    state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (wait_done) begin
                    state_next = WB;
                end
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= 32'b0;
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            if (accept) begin
                instr_q <= instruction;
            end
        end
    end

    // Operands are captured once in READ and held untouched through WB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_funct7    <= 7'b0;
            alu_funct3    <= 3'b0;
            alu_operand_0 <= 32'b0;
            alu_operand_1 <= 32'b0;
        end else if (state == READ) begin
            alu_funct7    <= dec_funct7;
            alu_funct3    <= dec_funct3;
            alu_operand_0 <= dec_operand_0;
            alu_operand_1 <= dec_operand_1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= CNT_LOAD;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_data <= 32'b0;
            wb_rd   <= 5'b0;
        end else if (wait_done) begin
            wb_data <= alu_destination;
            wb_rd   <= dec_rd;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue: two instances (ALU latency 1 and 3) driven
// against a transaction-level model of decode, timing and writeback.
module tb_alu_issue;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam int LAT [2] = '{1, 3};

    logic        clock;
    logic        reset_n         [2];
    logic        instr_valid     [2];
    logic        instr_ready     [2];
    logic [31:0] instruction     [2];
    logic        illegal         [2];
    logic [4:0]  rs1_addr        [2];
    logic [4:0]  rs2_addr        [2];
    logic [31:0] rs1_data        [2];
    logic [31:0] rs2_data        [2];
    logic        alu_enable      [2];
    logic [6:0]  alu_funct7      [2];
    logic [2:0]  alu_funct3      [2];
    logic [31:0] alu_operand_0   [2];
    logic [31:0] alu_operand_1   [2];
    logic [31:0] alu_destination [2];
    logic        wb_valid        [2];
    logic [4:0]  wb_rd           [2];
    logic [31:0] wb_data         [2];
    logic        busy            [2];

    logic [31:0] regs [32];
    logic        pipe_v [2][3];
    logic [31:0] pipe_d [2][3];

    int check_count = 0;
    int fail_count  = 0;

    alu_issue #(.ALU_LATENCY(1)) u_dut_lat1 (
        .clock(clock), .reset_n(reset_n[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready[0]), .instruction(instruction[0]), .illegal(illegal[0]),
        .rs1_addr(rs1_addr[0]), .rs2_addr(rs2_addr[0]), .rs1_data(rs1_data[0]),
        .rs2_data(rs2_data[0]), .alu_enable(alu_enable[0]), .alu_funct7(alu_funct7[0]),
        .alu_funct3(alu_funct3[0]), .alu_operand_0(alu_operand_0[0]),
        .alu_operand_1(alu_operand_1[0]), .alu_destination(alu_destination[0]),
        .wb_valid(wb_valid[0]), .wb_rd(wb_rd[0]), .wb_data(wb_data[0]), .busy(busy[0])
    );

    alu_issue #(.ALU_LATENCY(3)) u_dut_lat3 (
        .clock(clock), .reset_n(reset_n[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready[1]), .instruction(instruction[1]), .illegal(illegal[1]),
        .rs1_addr(rs1_addr[1]), .rs2_addr(rs2_addr[1]), .rs1_data(rs1_data[1]),
        .rs2_data(rs2_data[1]), .alu_enable(alu_enable[1]), .alu_funct7(alu_funct7[1]),
        .alu_funct3(alu_funct3[1]), .alu_operand_0(alu_operand_0[1]),
        .alu_operand_1(alu_operand_1[1]), .alu_destination(alu_destination[1]),
        .wb_valid(wb_valid[1]), .wb_rd(wb_rd[1]), .wb_data(wb_data[1]), .busy(busy[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] alu_ref(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = f7[5] ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Register file (combinational read) and ALU stub with the instance's latency.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rs1_data[i] = regs[rs1_addr[i]];
            rs2_data[i] = regs[rs2_addr[i]];
            alu_destination[i] = (pipe_v[i][LAT[i]-1] === 1'b1) ? pipe_d[i][LAT[i]-1] : 32'hBAD0BAD0;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            pipe_v[i][0] <= alu_enable[i];
            pipe_d[i][0] <= alu_ref(alu_funct7[i], alu_funct3[i], alu_operand_0[i], alu_operand_1[i]);
            for (int k = 1; k < 3; k++) begin
                pipe_v[i][k] <= pipe_v[i][k-1];
                pipe_d[i][k] <= pipe_d[i][k-1];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one instruction into an idle instance and checks every cycle until it is idle again.
    task automatic applyStimulus(input int idx, input logic [31:0] instr);
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] op0, op1, res;
        logic [4:0]  rd;
        logic        legal;
        opcode = instr[6:0];
        f3     = instr[14:12];
        rd     = instr[11:7];
        legal  = (opcode == OP) || (opcode == OP_IMM);
        op0    = regs[instr[19:15]];
        if (opcode == OP) begin
            op1 = regs[instr[24:20]];
            f7  = instr[31:25];
        end else begin
            op1 = {{20{instr[31]}}, instr[31:20]};
            f7  = (f3 == 3'b001 || f3 == 3'b101) ? instr[31:25] : 7'b0;
        end
        res = alu_ref(f7, f3, op0, op1);

        @(negedge clock);
        checkOutput("accept_ready", 32'(instr_ready[idx]), 32'd1);
        instr_valid[idx] = 1'b1;
        instruction[idx] = instr;
        @(posedge clock);
        #1;
        instr_valid[idx] = 1'b0;
        instruction[idx] = $urandom;
        @(negedge clock);
        if (!legal) begin
            checkOutput("illegal_pulse", 32'(illegal[idx]), 32'd1);
            checkOutput("illegal_ready", 32'(instr_ready[idx]), 32'd1);
            checkOutput("illegal_no_en", 32'(alu_enable[idx]), 32'd0);
            @(negedge clock);
            checkOutput("illegal_clear", 32'(illegal[idx]), 32'd0);
            checkOutput("illegal_no_en2", 32'(alu_enable[idx]), 32'd0);
            return;
        end
        checkOutput("read_illegal", 32'(illegal[idx]), 32'd0);
        checkOutput("read_ready", 32'(instr_ready[idx]), 32'd0);
        checkOutput("read_rs1", 32'(rs1_addr[idx]), 32'(instr[19:15]));
        checkOutput("read_rs2", 32'(rs2_addr[idx]), 32'(instr[24:20]));
        checkOutput("read_en", 32'(alu_enable[idx]), 32'd0);
        @(negedge clock);
        checkOutput("issue_en", 32'(alu_enable[idx]), 32'd1);
        checkOutput("issue_funct7", 32'(alu_funct7[idx]), 32'(f7));
        checkOutput("issue_funct3", 32'(alu_funct3[idx]), 32'(f3));
        checkOutput("issue_op0", alu_operand_0[idx], op0);
        checkOutput("issue_op1", alu_operand_1[idx], op1);
        for (int k = 1; k <= LAT[idx]; k++) begin
            @(negedge clock);
            checkOutput("wait_en", 32'(alu_enable[idx]), 32'd0);
            checkOutput("wait_wb", 32'(wb_valid[idx]), 32'd0);
            checkOutput("wait_op1", alu_operand_1[idx], op1);
        end
        @(negedge clock);
        checkOutput("wb_valid", 32'(wb_valid[idx]), 32'(rd != 5'd0));
        checkOutput("wb_rd", 32'(wb_rd[idx]), 32'(rd));
        checkOutput("wb_data", wb_data[idx], res);
        checkOutput("wb_op0", alu_operand_0[idx], op0);
        @(negedge clock);
        checkOutput("done_ready", 32'(instr_ready[idx]), 32'd1);
        checkOutput("done_wb", 32'(wb_valid[idx]), 32'd0);
    endtask

    function automatic logic [31:0] random_instr();
        logic [31:0] w;
        logic [6:0]  opc;
        int          pick;
        w    = $urandom;
        pick = $urandom_range(0, 9);
        if (pick < 6) begin
            w[6:0]   = OP;
            w[31:25] = w[31] ? 7'b0100000 : 7'b0000000;
        end else if (pick < 9) begin
            w[6:0] = OP_IMM;
            if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
                w[31:25] = w[31] ? 7'b0100000 : 7'b0000000;
            end
        end else begin
            opc = 7'($urandom);
            while (opc == OP || opc == OP_IMM) opc = 7'($urandom);
            w[6:0] = opc;
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cycles;
        int wb_seen;
        bit got;
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < 2; i++) begin
            reset_n[i]     = 1'b0;
            instr_valid[i] = 1'b0;
            instruction[i] = 32'd0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_ready", 32'(instr_ready[i]), 32'd1);
            checkOutput("reset_busy", 32'(busy[i]), 32'd0);
            checkOutput("reset_en", 32'(alu_enable[i]), 32'd0);
            checkOutput("reset_wb", {wb_data[i][31:1], wb_valid[i] | (|wb_rd[i]) | wb_data[i][0]}, 32'd0);
            checkOutput("reset_ops", alu_operand_0[i] | alu_operand_1[i], 32'd0);
        end
        @(negedge clock);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;

        // Directed cases on the latency-1 instance.
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        applyStimulus(0, {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OP});
        checkOutput("add_result", wb_data[0], 32'd12);
        regs[1] = 32'h10;
        applyStimulus(0, {12'hFFF, 5'd1, 3'b000, 5'd4, OP_IMM});
        checkOutput("addi_result", wb_data[0], 32'hF);
        applyStimulus(0, {7'b0100000, 5'd3, 5'd6, 3'b101, 5'd5, OP_IMM});
        applyStimulus(0, {25'h0AB_CDEF, 7'b0000011});

        // Back-to-back with rd=0 on the latency-3 instance.
        @(negedge clock);
        instr_valid[1] = 1'b1;
        instruction[1] = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OP};
        @(posedge clock);
        #1;
        instruction[1] = {7'b0, 5'd1, 5'd2, 3'b111, 5'd0, OP};
        got = 0;
        cycles = 0;
        wb_seen = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clock);
            if (wb_valid[1]) wb_seen++;
            if (instr_ready[1]) begin
                got = 1;
                cycles = c;
            end
        end
        checkOutput("b2b_gap", 32'(cycles), 32'd7);
        @(posedge clock);
        #1;
        instr_valid[1] = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (wb_valid[1]) wb_seen++;
        end
        checkOutput("rd0_no_wb", 32'(wb_seen), 32'd0);

        // Reset while waiting on the ALU.
        regs[1] = 32'h1234;
        @(negedge clock);
        instr_valid[1] = 1'b1;
        instruction[1] = {7'b0, 5'd2, 5'd1, 3'b000, 5'd9, OP};
        @(posedge clock);
        #1;
        instr_valid[1] = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset_n[1] = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy[1]), 32'd0);
        checkOutput("rst_ready", 32'(instr_ready[1]), 32'd1);
        checkOutput("rst_en_wb", 32'({alu_enable[1], wb_valid[1], illegal[1]}), 32'd0);
        checkOutput("rst_addr", 32'({rs1_addr[1], rs2_addr[1], wb_rd[1]}), 32'd0);
        checkOutput("rst_ops", alu_operand_0[1] | alu_operand_1[1] | wb_data[1], 32'd0);
        checkOutput("rst_funct", 32'({alu_funct7[1], alu_funct3[1]}), 32'd0);
        @(negedge clock);
        reset_n[1] = 1'b1;
        wb_seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (wb_valid[1]) wb_seen++;
        end
        checkOutput("rst_no_wb", 32'(wb_seen), 32'd0);
        checkOutput("rst_ready_after", 32'(instr_ready[1]), 32'd1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            for (int r = 1; r < 32; r++) regs[r] = $urandom;
            applyStimulus($urandom_range(0, 1), random_instr());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
